// File: rtl/door_control.sv
// Elevator door controller: Moore FSM sequencing open stroke, dwell and
// close stroke, with reversal on obstruction/request/overweight.
// A single 8-bit down-counter times both motor strokes and the open dwell.
module door_control #(
    parameter int unsigned MOVE_CYCLES  = 4,
    parameter int unsigned DWELL_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       open_req,
    input  logic       close_req,
    input  logic       obstruction,
    input  logic       weight_limit_exceeded,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_open,
    output logic       depart_ok,
    output logic       overweight_alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } door_state_t;

    localparam logic [7:0] MOVE_LOAD  = 8'(MOVE_CYCLES - 1);
    localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

    door_state_t state_q, state_n;
    logic [7:0]  cnt_q, cnt_n;

    // State and shared timer register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLOSED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next-state and timer update
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            CLOSED: begin
                if (open_req) begin
                    state_n = OPENING;
                    cnt_n   = MOVE_LOAD;
                end
            end
            OPENING: begin
                // Stroke cannot be interrupted; inputs are ignored here
                if (cnt_q == '0) begin
                    state_n = OPEN;
                    cnt_n   = DWELL_LOAD;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end
            OPEN: begin
                if (open_req) begin
                    cnt_n = DWELL_LOAD;
                end else if (cnt_q == '0) begin
                    // Dwell expired: leave only when the doorway is clear
                    if (!weight_limit_exceeded && !obstruction) begin
                        state_n = CLOSING;
                        cnt_n   = MOVE_LOAD;
                    end
                end else if (close_req) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end
            CLOSING: begin
                if (obstruction || open_req || weight_limit_exceeded) begin
                    // Full reversal: a complete open stroke is timed again
                    state_n = OPENING;
                    cnt_n   = MOVE_LOAD;
                end else if (cnt_q == '0) begin
                    state_n = CLOSED;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end
            default: begin
                state_n = CLOSED;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode from state, plus the two weight-qualified flags
    always_comb begin
        motor_open       = (state_q == OPENING);
        motor_close      = (state_q == CLOSING);
        door_open        = (state_q == OPEN);
        depart_ok        = (state_q == CLOSED) && !weight_limit_exceeded;
        overweight_alarm = ((state_q == OPEN) || (state_q == OPENING)) && weight_limit_exceeded;
        state            = state_q;
    end

endmodule

// File: tb/tb_door_control.sv
// Self-checking bench for door_control: directed scenarios followed by a
// random run, all compared against a phase/elapsed-time reference model.
module tb_door_control;

    localparam int MOVE  = 4;
    localparam int DWELL = 10;

    localparam int P_CLOSED  = 0;
    localparam int P_OPENING = 1;
    localparam int P_OPEN    = 2;
    localparam int P_CLOSING = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       open_req = 1'b0;
    logic       close_req = 1'b0;
    logic       obstruction = 1'b0;
    logic       weight_limit_exceeded = 1'b0;
    logic       motor_open, motor_close, door_open, depart_ok, overweight_alarm;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Reference model: current phase and cycles spent in it (1 = first cycle)
    int m_phase = P_CLOSED;
    int m_el    = 0;

    door_control #(.MOVE_CYCLES(MOVE), .DWELL_CYCLES(DWELL)) dut (
        .clk(clk),
        .reset(reset),
        .open_req(open_req),
        .close_req(close_req),
        .obstruction(obstruction),
        .weight_limit_exceeded(weight_limit_exceeded),
        .motor_open(motor_open),
        .motor_close(motor_close),
        .door_open(door_open),
        .depart_ok(depart_ok),
        .overweight_alarm(overweight_alarm),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, ".state"}, int'(state), m_phase);
        check({where, ".motor_open"}, int'(motor_open), int'(m_phase == P_OPENING));
        check({where, ".motor_close"}, int'(motor_close), int'(m_phase == P_CLOSING));
        check({where, ".door_open"}, int'(door_open), int'(m_phase == P_OPEN));
        check({where, ".depart_ok"}, int'(depart_ok),
              int'(m_phase == P_CLOSED && !weight_limit_exceeded));
        check({where, ".alarm"}, int'(overweight_alarm),
              int'((m_phase == P_OPEN || m_phase == P_OPENING) && weight_limit_exceeded));
    endtask

    // Advance the model by one clock edge using the currently applied inputs
    task automatic model_step();
        case (m_phase)
            P_CLOSED: begin
                if (open_req) begin m_phase = P_OPENING; m_el = 1; end
            end
            P_OPENING: begin
                if (m_el >= MOVE) begin m_phase = P_OPEN; m_el = 1; end
                else m_el++;
            end
            P_OPEN: begin
                if (open_req) m_el = 1;
                else if (m_el >= DWELL) begin
                    if (!weight_limit_exceeded && !obstruction) begin
                        m_phase = P_CLOSING; m_el = 1;
                    end
                end else if (close_req) m_el = DWELL;
                else m_el++;
            end
            default: begin
                if (obstruction || open_req || weight_limit_exceeded) begin
                    m_phase = P_OPENING; m_el = 1;
                end else if (m_el >= MOVE) begin
                    m_phase = P_CLOSED; m_el = 0;
                end else m_el++;
            end
        endcase
    endtask

    // One clock cycle: apply inputs mid-cycle, check, clock, check again
    task automatic tick(input logic o, input logic c, input logic ob, input logic w);
        @(negedge clk);
        open_req = o;
        close_req = c;
        obstruction = ob;
        weight_limit_exceeded = w;
        #1;
        check_outputs("pre");
        model_step();
        @(posedge clk);
        #1;
        check_outputs("post");
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        m_phase = P_CLOSED;
        m_el = 0;
        #1;
        check("rst.state", int'(state), P_CLOSED);
        check("rst.motor_open", int'(motor_open), 0);
        check("rst.motor_close", int'(motor_close), 0);
        check_outputs("rst");
        @(posedge clk);
        #2;
        check_outputs("rst_hold");
        reset = 1'b0;
    endtask

    task automatic run_until(input int ph, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (m_phase == ph) break;
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("reach_phase", int'(state), ph);
    endtask

    initial begin
        int n_mo, n_do, n_mc;

        // Reset state
        async_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Normal cycle with a one-cycle open pulse
        n_mo = 0; n_do = 0; n_mc = 0;
        for (int i = 0; i < 23; i++) begin
            if (i == 0) tick(1'b1, 1'b0, 1'b0, 1'b0);
            else        tick(1'b0, 1'b0, 1'b0, 1'b0);
            n_mo += int'(motor_open);
            n_do += int'(door_open);
            n_mc += int'(motor_close);
        end
        check("normal.open_cycles", n_mo, MOVE);
        check("normal.dwell_cycles", n_do, DWELL);
        check("normal.close_cycles", n_mc, MOVE);
        check("normal.end_state", int'(state), P_CLOSED);
        check("normal.depart_ok", int'(depart_ok), 1);

        // Overweight holds the door open past dwell
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        run_until(P_OPEN, 10);
        for (int i = 0; i < DWELL + 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovw.held_open", int'(state), P_OPEN);
        check("ovw.alarm", int'(overweight_alarm), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovw.closing_next", int'(state), P_CLOSING);
        run_until(P_CLOSED, 10);

        // Obstruction in the second closing cycle reverses the door
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        run_until(P_CLOSING, 30);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("rev.opening", int'(state), P_OPENING);
        n_mo = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (!motor_open) break;
            n_mo++;
        end
        check("rev.open_cycles", n_mo, MOVE);

        // open_req beats close_req; close_req alone closes two edges later
        run_until(P_OPEN, 10);
        for (int i = 0; i < DWELL + 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("prio.still_open", int'(state), P_OPEN);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("prio.edge1", int'(state), P_OPEN);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("prio.edge2", int'(state), P_CLOSING);
        run_until(P_CLOSED, 10);

        // Reset during the open stroke
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid.opening", int'(motor_open), 1);
        async_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid.resume", int'(state), P_OPENING);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) async_reset();
            else tick(1'($urandom_range(3) == 0), 1'($urandom_range(4) == 0),
                      1'($urandom_range(5) == 0), 1'($urandom_range(7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
